slave_sp_param: RTL and testbench
=================================

// Module: slave_sp_param
// PURPOSE
//  Parametrised serial-bus memory slave with split-transaction support.
//  Next generation of the fixed 4K/8-bit split slave: address, data and frame widths are parameters.
//  Sits behind the bus arbiter/decoder.
//  Sequence: serial address frame -> address ACK -> serial write (with ACK) or serial read (optionally split).
// PARAMETERS
//  ADDR_W    12     memory address bits; depth = 2**ADDR_W words
//  DATA_W    8      word width; serial bits per data phase
//  DEV_W     2      device-select bits at the top of the address frame; received and ignored
//  INIT_VAL  8'hAD  initial memory content (DATA_W wide)
// PORTS
//  CLK           in   1       clock, rising edge
//  RST           in   1       synchronous reset, active-high
//  AD_SEL        in   1       slave selected; frames address and data phases
//  B_RW          in   1       1 = write, 0 = read; sampled in ACK_A
//  B_BUS_OUT     in   1       serial master->slave line, LSB first
//  B_SPLIT       in   1       arbiter split in force
//  B_SPL_RESUME  in   1       arbiter grants resume of split read
//  S_SPLIT       in   1       local request to split the current read
//  B_BUS_IN      out  1       serial slave->master read data, LSB first
//  B_ACK         out  1       acknowledge pulse (address / write)
//  B_READY       out  1       slave idle and ready for a new frame
//  B_SBSY        out  1       split-busy pulse to the arbiter
//  S_DOUT        out  DATA_W  last word written
//  S_DVALID      out  1       S_DOUT updated, one-cycle pulse
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (RST=1 at CLK edge): state=IDLE, counters=0, B_READY=1.
//    All other outputs 0, S_DOUT=0. Memory unchanged. An in-flight write is discarded.
//  - Frame width: FW = DEV_W+ADDR_W bits.
//    Memory address = frame[ADDR_W-1:0]; frame[FW-1:ADDR_W] is ignored.
//  - Bit counter width: $clog2(max(FW,DATA_W))+1. Cleared on every state change.
//  - FSM:
//    IDLE:  B_READY=1. AD_SEL=1 -> ADDR.
//    ADDR:  each cycle with AD_SEL=1, frame[cnt]<=B_BUS_OUT, cnt++.
//           After FW bits -> ACK_A. AD_SEL=0 mid-frame -> IDLE with no ACK.
//    ACK_A: B_ACK=1 for exactly this cycle; address latched.
//           B_RW=1 -> WRITE.
//           B_RW=0 & S_SPLIT=1 -> B_SBSY=1 for one cycle, then HOLD.
//           B_RW=0 & S_SPLIT=0 -> READ.
//    WRITE: DATA_W cycles; shift[cnt]<=B_BUS_OUT. After the last bit -> ACK_W.
//           AD_SEL=0 before the last bit -> IDLE, no memory write, no ACK.
//    ACK_W: mem[addr]<=shift. B_ACK=1 for one cycle.
//           Next cycle: S_DOUT=shift, S_DVALID=1 for one cycle. -> IDLE.
//    READ:  B_BUS_IN=mem[addr][cnt], one bit per cycle, registered.
//           Bit 0 appears the cycle after ACK_A (or after HOLD exit).
//           After DATA_W bits -> IDLE with B_BUS_IN=0.
//           B_SPLIT=1 & B_SPL_RESUME=0 -> HOLD.
//    HOLD:  B_BUS_IN=0, B_READY=0. Stays while B_SPLIT & ~B_SPL_RESUME.
//           On exit -> READ, restarting at bit 0.
//  - B_READY=0 in every state except IDLE.
//  - Simultaneous events: RST has priority over everything; split-HOLD has priority over READ completion.
//  - Back-to-back: a new frame may start the cycle after IDLE is re-entered.
//  - Address wraps modulo 2**ADDR_W, with no error.
// CONFIGURATION
//  SLAVE_SPLIT_EN defined: split logic as above (S_SPLIT, B_SPLIT, B_SPL_RESUME honoured).
//  SLAVE_SPLIT_EN undefined:
//   - HOLD is not built; B_SBSY is tied 0.
//   - S_SPLIT, B_SPLIT and B_SPL_RESUME are ignored.
//   - Reads always go ACK_A -> READ.
// TESTING (DATA_W=8, ADDR_W=12, DEV_W=2, FW=14)
//  1. Write 0x5A to address 0x123:
//     -> B_ACK pulse after the 14th address bit.
//     -> B_ACK pulse after the 8th data bit.
//     -> S_DOUT=0x5A, S_DVALID pulse; B_READY returns to 1.
//  2. Read 0x123 -> B_BUS_IN = 0,1,0,1,1,0,1,0 on consecutive cycles, then IDLE.
//  3. Split read (S_SPLIT=1 in ACK_A, B_SPLIT=1) -> B_SBSY pulse, then HOLD with B_BUS_IN=0.
//     B_SPL_RESUME=1 -> full 8-bit serial read of 0x5A.
//  4. AD_SEL=0 after 5 address bits -> no B_ACK, IDLE; read 0x123 still returns 0x5A.
//  5. RST=1 on write data bit 4 -> all outputs at reset values; read back returns the old value.
//  6. Read of unwritten address 0xFFF -> serial INIT_VAL 0xAD (1,0,1,1,0,1,0,1).
//     With SLAVE_SPLIT_EN undefined, S_SPLIT=1 -> no B_SBSY, immediate read.

Source files
------------

// File: rtl/slave_sp_param_if.sv
// slave_sp_param_if: serial-bus handshake and data signals between the bus
// master side (arbiter/decoder or testbench) and the slave_sp_param memory slave.
interface slave_sp_param_if #(
  parameter int DATA_W = 8
);

  // master -> slave
  logic              ad_sel;
  logic              b_rw;
  logic              b_bus_out;
  logic              b_split;
  logic              b_spl_resume;
  logic              s_split;

  // slave -> master
  logic              b_bus_in;
  logic              b_ack;
  logic              b_ready;
  logic              b_sbsy;
  logic [DATA_W-1:0] s_dout;
  logic              s_dvalid;

  modport master (
    output ad_sel, b_rw, b_bus_out, b_split, b_spl_resume, s_split,
    input  b_bus_in, b_ack, b_ready, b_sbsy, s_dout, s_dvalid
  );

  modport slave (
    input  ad_sel, b_rw, b_bus_out, b_split, b_spl_resume, s_split,
    output b_bus_in, b_ack, b_ready, b_sbsy, s_dout, s_dvalid
  );

endinterface

// File: rtl/slave_sp_param.sv
// slave_sp_param: parametrised serial-bus memory slave with split-read support.
// Serial address frame (LSB first) -> address ACK -> serial write with ACK, or
// serial read (optionally parked in HOLD while the arbiter splits the bus).
// Optional feature macro: SLAVE_SPLIT_EN
//   defined   : HOLD state built, S_SPLIT / B_SPLIT / B_SPL_RESUME honoured, B_SBSY driven
//   undefined : reads always go ACK_A -> READ, split inputs ignored, B_SBSY tied 0
// All outputs are registered; each output flop is loaded from the next state so
// it is valid during the state it belongs to.
module slave_sp_param #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 8,
  parameter int                DEV_W    = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = 8'hAD
) (
  input  logic            clk,
  input  logic            rst,
  slave_sp_param_if.slave bus
);

  localparam int FW    = DEV_W + ADDR_W;
  localparam int MAXW  = (FW > DATA_W) ? FW : DATA_W;
  localparam int CW    = $clog2(MAXW) + 1;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [CW-1:0] FW_LAST = CW'(FW - 1);
  localparam logic [CW-1:0] DW_LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_ACK_A = 3'd2,
    S_WRITE = 3'd3,
    S_ACK_W = 3'd4,
    S_READ  = 3'd5
`ifdef SLAVE_SPLIT_EN
    ,
    S_HOLD  = 3'd6
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Datapath registers
  logic [FW-1:0]     frame_q, frame_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_sh_q, wr_sh_d;
  logic [DATA_W-1:0] rd_sh_q, rd_sh_d;
  logic              mem_we;

  // Registered outputs
  logic              b_bus_in_q, b_bus_in_d;
  logic              b_ack_q, b_ack_d;
  logic              b_ready_q, b_ready_d;
  logic [DATA_W-1:0] s_dout_q, s_dout_d;
  logic              s_dvalid_q, s_dvalid_d;

  // Split qualifiers
  logic              split_req;   // local request to split the read, seen in ACK_A
  logic              split_hold;  // arbiter keeps the bus split

  // NOTE: the storage array is deliberately outside the reset domain: a reset
  // must leave contents intact, and it maps onto plain RAM only without one.
  // Its power-up content comes from the declaration initialiser.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT_VAL};

`ifdef SLAVE_SPLIT_EN
  logic              b_sbsy_q, b_sbsy_d;

  assign split_req  = bus.s_split;
  assign split_hold = bus.b_split & ~bus.b_spl_resume;
`else
  logic              unused_split;

  assign split_req    = 1'b0;
  assign split_hold   = 1'b0;
  assign unused_split = ^{bus.s_split, bus.b_split, bus.b_spl_resume, split_req, split_hold};
`endif

  // Next-state and bit-counter logic; counter clears on every state change
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ad_sel) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (!bus.ad_sel) begin
          state_d = S_IDLE;
        end else if (cnt_q == FW_LAST) begin
          state_d = S_ACK_A;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACK_A: begin
        if (bus.b_rw) begin
          state_d = S_WRITE;
`ifdef SLAVE_SPLIT_EN
        end else if (split_req) begin
          state_d = S_HOLD;
`endif
        end else begin
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (!bus.ad_sel) begin
          state_d = S_IDLE;
        end else if (cnt_q == DW_LAST) begin
          state_d = S_ACK_W;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACK_W: begin
        state_d = S_IDLE;
      end
      S_READ: begin
`ifdef SLAVE_SPLIT_EN
        // A split takes priority over completing the last bit.
        if (split_hold) begin
          state_d = S_HOLD;
        end else
`endif
        if (cnt_q == DW_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef SLAVE_SPLIT_EN
      S_HOLD: begin
        if (!split_hold) state_d = S_READ;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Datapath: address frame shift-in, write shift-in, read word rotation
  always_comb begin
    frame_d = frame_q;
    addr_d  = addr_q;
    wr_sh_d = wr_sh_q;
    rd_sh_d = rd_sh_q;
    mem_we  = 1'b0;

    // LSB first: after FW right shifts the first bit lands at frame bit 0.
    if (state_q == S_ADDR && bus.ad_sel) frame_d = {bus.b_bus_out, frame_q[FW-1:1]};
    if (state_q == S_ADDR && state_d == S_ACK_A) addr_d = frame_d[ADDR_W-1:0];

    if (state_q == S_WRITE && bus.ad_sel) wr_sh_d = {bus.b_bus_out, wr_sh_q[DATA_W-1:1]};

    // The word is fetched on READ entry (also after HOLD, restarting at bit 0)
    // and rotated so the bit to present is always at position 0.
    if (state_d == S_READ) begin
      if (state_q != S_READ) rd_sh_d = mem_q[addr_q];
      else                   rd_sh_d = {rd_sh_q[0], rd_sh_q[DATA_W-1:1]};
    end

    if (state_q == S_ACK_W) mem_we = 1'b1;
  end

  // Output logic: values for the output flops, derived from the next state
  always_comb begin
    b_ready_d  = (state_d == S_IDLE);
    b_ack_d    = (state_d == S_ACK_A) || (state_d == S_ACK_W);
    b_bus_in_d = (state_d == S_READ) ? rd_sh_d[0] : 1'b0;
    s_dvalid_d = (state_q == S_ACK_W);
    s_dout_d   = (state_q == S_ACK_W) ? wr_sh_q : s_dout_q;
`ifdef SLAVE_SPLIT_EN
    b_sbsy_d   = (state_q == S_ACK_A) && (state_d == S_HOLD);
`endif
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      b_ready_q  <= 1'b1;
      b_ack_q    <= 1'b0;
      b_bus_in_q <= 1'b0;
      s_dvalid_q <= 1'b0;
      s_dout_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      b_ready_q  <= b_ready_d;
      b_ack_q    <= b_ack_d;
      b_bus_in_q <= b_bus_in_d;
      s_dvalid_q <= s_dvalid_d;
      s_dout_q   <= s_dout_d;
    end
  end

`ifdef SLAVE_SPLIT_EN
  // Split-busy pulse register
  always_ff @(posedge clk) begin
    if (rst) b_sbsy_q <= 1'b0;
    else     b_sbsy_q <= b_sbsy_d;
  end

  assign bus.b_sbsy = b_sbsy_q;
`else
  assign bus.b_sbsy = 1'b0;
`endif

  // Datapath registers: always loaded before being consumed, so no reset
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    addr_q  <= addr_d;
    wr_sh_q <= wr_sh_d;
    rd_sh_q <= rd_sh_d;
  end

  // Memory write in ACK_W; reset in the same cycle discards the write
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[addr_q] <= wr_sh_q;
  end

  assign bus.b_bus_in = b_bus_in_q;
  assign bus.b_ack    = b_ack_q;
  assign bus.b_ready  = b_ready_q;
  assign bus.s_dout   = s_dout_q;
  assign bus.s_dvalid = s_dvalid_q;

endmodule

// File: tb/tb_slave_sp_param.sv
// tb_slave_sp_param: self-checking bench for slave_sp_param.
// Directed protocol scenarios followed by randomized reads/writes checked
// against a word-array memory model. Honours SLAVE_SPLIT_EN like the design.
`timescale 1ns/1ps
module tb_slave_sp_param;

  localparam int         ADDR_W   = 12;
  localparam int         DATA_W   = 8;
  localparam int         DEV_W    = 2;
  localparam int         FW       = DEV_W + ADDR_W;
  localparam logic [7:0] INIT_VAL = 8'hAD;

  logic clk = 1'b0;
  logic rst;

  slave_sp_param_if #(.DATA_W(DATA_W)) bus ();

  slave_sp_param #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEV_W   (DEV_W),
    .INIT_VAL(INIT_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] ref_mem [1 << ADDR_W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},  32'(bus.b_ready),  32'd1);
    check({tag, "_ack"},    32'(bus.b_ack),    32'd0);
    check({tag, "_busin"},  32'(bus.b_bus_in), 32'd0);
    check({tag, "_sbsy"},   32'(bus.b_sbsy),   32'd0);
  endtask

  task automatic idle(input int n);
    bus.ad_sel = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check_idle_outputs("idle");
    end
  endtask

  // Address frame; abort_at >= 0 drops AD_SEL before that bit.
  task automatic send_frame(input logic [ADDR_W-1:0] addr, input logic [DEV_W-1:0] dev,
                            input int abort_at);
    logic [FW-1:0] f;
    f = {dev, addr};
    bus.ad_sel = 1'b1;
    tick();
    check("frame_start_ready", 32'(bus.b_ready),  32'd0);
    check("frame_dvalid_low",  32'(bus.s_dvalid), 32'd0);
    for (int i = 0; i < FW; i++) begin
      if (i == abort_at) begin
        bus.ad_sel = 1'b0;
        tick();
        check("abort_ready", 32'(bus.b_ready), 32'd1);
        check("abort_ack",   32'(bus.b_ack),   32'd0);
        return;
      end
      bus.b_bus_out = f[i];
      tick();
      check("addr_ack", 32'(bus.b_ack), 32'(i == FW - 1));
    end
  endtask

  // Write; rst_at >= 0 asserts reset on that data bit.
  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DEV_W-1:0] dev,
                          input logic [7:0] data, input int rst_at);
    send_frame(addr, dev, -1);
    bus.b_rw = 1'b1;
    tick();
    check("wr_ack_a_drop", 32'(bus.b_ack), 32'd0);
    for (int j = 0; j < DATA_W; j++) begin
      bus.b_bus_out = data[j];
      if (j == rst_at) rst = 1'b1;
      tick();
      if (j == rst_at) begin
        rst        = 1'b0;
        bus.ad_sel = 1'b0;
        bus.b_rw   = 1'b0;
        check_idle_outputs("rst_mid_write");
        check("rst_mid_write_dout",   32'(bus.s_dout),   32'd0);
        check("rst_mid_write_dvalid", 32'(bus.s_dvalid), 32'd0);
        return;
      end
      check("wr_ack", 32'(bus.b_ack), 32'(j == DATA_W - 1));
      check("wr_ready", 32'(bus.b_ready), 32'd0);
    end
    bus.b_rw = 1'b0;
    tick();
    check("wr_dvalid", 32'(bus.s_dvalid), 32'd1);
    check("wr_dout",   32'(bus.s_dout),   32'(data));
    check("wr_ready",  32'(bus.b_ready),  32'd1);
    check("wr_ack_w_drop", 32'(bus.b_ack), 32'd0);
    ref_mem[addr] = data;
  endtask

  // Read; split_req requests a split in ACK_A, mid_split >= 0 splits the bus
  // while that bit is on the line (only meaningful with the split build).
  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [DEV_W-1:0] dev,
                         input bit split_req, input int mid_split, input int hold_cycles);
    logic [7:0] word;
    int         msplit;
    word   = ref_mem[addr];
    msplit = mid_split;
    send_frame(addr, dev, -1);
    bus.ad_sel       = 1'b0;
    bus.b_rw         = 1'b0;
    bus.s_split      = split_req;
    bus.b_split      = split_req;
    bus.b_spl_resume = 1'b0;
    tick();
`ifdef SLAVE_SPLIT_EN
    if (split_req) begin
      check("split_sbsy",  32'(bus.b_sbsy),   32'd1);
      check("split_busin", 32'(bus.b_bus_in), 32'd0);
      check("split_ready", 32'(bus.b_ready),  32'd0);
      bus.s_split = 1'b0;
      for (int h = 0; h < hold_cycles; h++) begin
        tick();
        check("hold_sbsy",  32'(bus.b_sbsy),   32'd0);
        check("hold_busin", 32'(bus.b_bus_in), 32'd0);
        check("hold_ready", 32'(bus.b_ready),  32'd0);
      end
      bus.b_spl_resume = 1'b1;
      tick();
      bus.b_split      = 1'b0;
      bus.b_spl_resume = 1'b0;
    end
`else
    check("nosplit_sbsy", 32'(bus.b_sbsy), 32'd0);
    bus.s_split = 1'b0;
    bus.b_split = 1'b0;
`endif
    for (int k = 0; k < DATA_W; k++) begin
      check("rd_bit",   32'(bus.b_bus_in), 32'(word[k]));
      check("rd_ready", 32'(bus.b_ready),  32'd0);
`ifdef SLAVE_SPLIT_EN
      if (k == msplit) begin
        bus.b_split = 1'b1;
        tick();
        check("mid_hold_busin", 32'(bus.b_bus_in), 32'd0);
        check("mid_hold_ready", 32'(bus.b_ready),  32'd0);
        check("mid_hold_sbsy",  32'(bus.b_sbsy),   32'd0);
        tick();
        check("mid_hold_stay",  32'(bus.b_bus_in), 32'd0);
        bus.b_spl_resume = 1'b1;
        tick();
        bus.b_split      = 1'b0;
        bus.b_spl_resume = 1'b0;
        msplit = -1;
        k      = -1;
        continue;
      end
`endif
      tick();
    end
    check("rd_end_busin", 32'(bus.b_bus_in), 32'd0);
    check("rd_end_ready", 32'(bus.b_ready),  32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) ref_mem[a] = INIT_VAL;

    rst              = 1'b1;
    bus.ad_sel       = 1'b0;
    bus.b_rw         = 1'b0;
    bus.b_bus_out    = 1'b0;
    bus.b_split      = 1'b0;
    bus.b_spl_resume = 1'b0;
    bus.s_split      = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset_dout",   32'(bus.s_dout),   32'd0);
    check("reset_dvalid", 32'(bus.s_dvalid), 32'd0);
    rst = 1'b0;
    idle(2);

    // 1. write 0x5A to 0x123 (device bits ignored)
    do_write(12'h123, 2'b10, 8'h5A, -1);
    idle(1);
    // 2. plain read back
    do_read(12'h123, 2'b00, 1'b0, -1, 0);
    // 3. split request in ACK_A (ignored without the split build)
    do_read(12'h123, 2'b01, 1'b1, -1, 3);
    // 4. aborted address frame, then read still returns 0x5A
    send_frame(12'h123, 2'b00, 5);
    idle(1);
    do_read(12'h123, 2'b00, 1'b0, -1, 0);
    // 5. reset on write data bit 4 discards the write
    do_write(12'h123, 2'b00, 8'h3C, 4);
    idle(1);
    do_read(12'h123, 2'b11, 1'b0, -1, 0);
    // 6. unwritten top address returns INIT_VAL
    do_read(12'hFFF, 2'b11, 1'b0, -1, 0);
    // split at the final bit takes priority over completion
    do_read(12'h123, 2'b00, 1'b0, 7, 0);
    // back-to-back writes with no idle gap between transactions
    do_write(12'h001, 2'b01, 8'hC3, -1);
    do_write(12'h002, 2'b10, 8'h81, -1);
    idle(1);
    do_read(12'h001, 2'b00, 1'b0, -1, 0);
    do_read(12'h002, 2'b00, 1'b0, -1, 0);

    for (int n = 0; n < 40; n++) begin
      logic [ADDR_W-1:0] a;
      logic [DEV_W-1:0]  d;
      a = ADDR_W'($urandom_range(0, 47));
      d = DEV_W'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, d, 8'($urandom_range(0, 255)), -1);
      end else begin
        do_read(a, d, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : -1,
                $urandom_range(0, 4));
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
